wb_gpio_ctrl: RTL and testbench

Parametrised Wishbone-slave GPIO controller for the soc, replacing direct pin wiring with a register-mapped bank of up to 64 pins. It provides per-pin output data, per-pin output enable (driven active-low onto the Caravel oeb pins), synchronised input sampling, and per-pin rising/falling edge interrupts with write-1-to-clear status. It sits on the soc's Caravel Wishbone bus and drives the GPIO pins and one interrupt line.

---
 rtl/wb_gpio_ctrl.sv | 149 ++++++++++++++
 tb/tb_wb_gpio_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_ctrl.sv
// Wishbone-slave GPIO bank: output data/enable registers, synchronised inputs,
// and per-pin rise/fall edge interrupts with write-1-to-clear status.
module wb_gpio_ctrl #(
  parameter int          N_PINS      = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [N_PINS-1:0] gpio_i,
  output logic [N_PINS-1:0] gpio_o,
  output logic [N_PINS-1:0] gpio_oeb_no,
  output logic              irq_o
);

  localparam logic [63:0] PIN_MASK  = (N_PINS >= 64) ? {64{1'b1}} : ((64'd1 << N_PINS) - 64'd1);
  localparam int          GW        = $clog2(SYNC_STAGES + 2);
  localparam logic [GW-1:0] GUARD_END = GW'(SYNC_STAGES + 1);

  localparam logic [2:0] REG_DIN  = 3'd0;
  localparam logic [2:0] REG_DOUT = 3'd1;
  localparam logic [2:0] REG_OE   = 3'd2;
  localparam logic [2:0] REG_RISE = 3'd3;
  localparam logic [2:0] REG_FALL = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;
  localparam logic [2:0] REG_SET  = 3'd6;
  localparam logic [2:0] REG_CLR  = 3'd7;

  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] prev_q;
  logic [63:0]       data_out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [GW-1:0]     guard_q;
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              irq_q;

  // Handshake: a request (cyc & stb & window hit) is accepted on the edge
  // where ack is low; ack is then high for exactly one cycle, carrying read
  // data, and the master must drop or change its request before the next
  // edge to avoid a second access.
  logic        hit, access, wr, in_map, hi;
  logic [2:0]  reg_sel;
  logic [31:0] lane_mask;
  logic [63:0] wmask, wbits;
  logic [63:0] din64, rise64, fall64, edge_ev;
  logic [63:0] data_out_d, status_d, rdata64;
  logic [31:0] rdata32;
  logic        unused_bits;

  assign unused_bits = &{1'b0, wbs_adr_i[1:0]};

  assign hit       = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign access    = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr        = access & wbs_we_i;
  assign in_map    = (wbs_adr_i[7:6] == 2'b00);
  assign reg_sel   = wbs_adr_i[5:3];
  assign hi        = wbs_adr_i[2];
  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask     = (hi ? {lane_mask, 32'h0} : {32'h0, lane_mask}) & PIN_MASK;
  assign wbits     = {wbs_dat_i, wbs_dat_i} & wmask;

  always_comb begin
    din64  = '0;
    rise64 = '0;
    fall64 = '0;
    din64[N_PINS-1:0]  = sync_q[SYNC_STAGES-1];
    rise64[N_PINS-1:0] = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall64[N_PINS-1:0] = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Edges are ignored until the synchroniser has flushed its reset zeros.
  assign edge_ev = (guard_q == GUARD_END) ? ((rise64 & rise_en_q) | (fall64 & fall_en_q)) : '0;

  always_comb begin
    data_out_d = data_out_q;
    status_d   = status_q;
    if (wr && in_map) begin
      case (reg_sel)
        REG_DOUT: data_out_d = (data_out_q & ~wmask) | wbits;
        REG_SET:  data_out_d = data_out_q | wbits;
        REG_CLR:  data_out_d = data_out_q & ~wbits;
        REG_STAT: status_d   = status_q & ~wbits;
        default:  data_out_d = data_out_q;
      endcase
    end
    status_d = status_d | edge_ev;
  end

  always_comb begin
    rdata64 = '0;
    case (reg_sel)
      REG_DIN:  rdata64 = din64;
      REG_DOUT: rdata64 = data_out_q;
      REG_OE:   rdata64 = oe_q;
      REG_RISE: rdata64 = rise_en_q;
      REG_FALL: rdata64 = fall_en_q;
      REG_STAT: rdata64 = status_q;
      default:  rdata64 = '0;
    endcase
    rdata32 = hi ? rdata64[63:32] : rdata64[31:0];
    if (!in_map) rdata32 = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      oe_q       <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      guard_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (guard_q != GUARD_END) guard_q <= guard_q + GW'(1);

      data_out_q <= data_out_d;
      status_q   <= status_d;
      if (wr && in_map && reg_sel == REG_OE)   oe_q      <= (oe_q & ~wmask) | wbits;
      if (wr && in_map && reg_sel == REG_RISE) rise_en_q <= (rise_en_q & ~wmask) | wbits;
      if (wr && in_map && reg_sel == REG_FALL) fall_en_q <= (fall_en_q & ~wmask) | wbits;

      ack_q <= access;
      dat_q <= (access && !wbs_we_i) ? rdata32 : 32'h0;
      irq_q <= |status_q;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign gpio_o      = data_out_q[N_PINS-1:0];
  assign gpio_oeb_no = ~oe_q[N_PINS-1:0];
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl: bus tasks push expected read data into a
// queue, an ack-driven monitor pops and compares; pin/irq timing checked inline.
module tb_wb_gpio_ctrl;
  localparam int          N = 38;
  localparam logic [31:0] B = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   dat_w, adr;
  logic          ack;
  logic [31:0]   dat_r;
  logic [N-1:0]  gpio_in, gpio_out, gpio_oeb;
  logic          irq;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];  // {is_read, expected read data}
  logic        ack_prev = 1'b0;

  wb_gpio_ctrl #(.N_PINS(N), .BASE_ADDR(B), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_w), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_oeb_no(gpio_oeb), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack consumes one expectation; read data is compared.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ack) begin
        check("ack_width", {63'h0, ack_prev}, 64'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 64'h1, 64'h0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          if (e[32]) check("rd_data", {32'h0, dat_r}, {32'h0, e[31:0]});
        end
      end else begin
        check("dat_idle", {32'h0, dat_r}, 64'h0);
      end
    end
    ack_prev <= ack;
  end

  // Callers are aligned to posedge+1; the request is sampled on the next edge.
  task automatic wb_start(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] exp);
    exp_q.push_back({~w, w ? 32'h0 : exp});
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
  endtask

  task automatic wb_wait();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      check("ack_timeout", 64'h0, 64'h1);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    wb_start(1'b1, a, s, d, 32'h0);
    wb_wait();
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
    wb_start(1'b0, a, 4'hF, 32'h0, exp);
    wb_wait();
  endtask

  task automatic wb_no_ack(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic seen;
    seen = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = 4'hF; dat_w = d;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("no_ack", {63'h0, seen}, 64'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    dat_w = '0; adr = '0; gpio_in = '1;
    idle(3);
    check("rst_gpio_o", {26'h0, gpio_out}, 64'h0);
    check("rst_oeb", {26'h0, gpio_oeb}, {26'h0, {N{1'b1}}});
    check("rst_irq", {63'h0, irq}, 64'h0);
    check("rst_ack", {63'h0, ack}, 64'h0);
    check("rst_dat", {32'h0, dat_r}, 64'h0);

    // Enable every rise on the first edge after release: only the guard
    // keeps the pins that were high through reset from raising status.
    wb_start(1'b1, B + 32'h18, 4'hF, 32'hFFFF_FFFF, 32'h0);
    rst_n = 1'b1;
    wb_wait();
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      seen = seen | irq;
    end
    check("guard_irq", {63'h0, seen}, 64'h0);
    wb_read(B + 32'h28, 32'h0);
    wb_read(B + 32'h00, 32'hFFFF_FFFF);
    wb_read(B + 32'h04, 32'h0000_003F);
    wb_write(B + 32'h18, 4'hF, 32'h0);
    gpio_in = '0;
    idle(5);
    wb_read(B + 32'h28, 32'h0);

    // Output path with partial byte lanes.
    wb_write(B + 32'h10, 4'hF, 32'hFFFF_FFFF);
    check("oeb_lo", {32'h0, gpio_oeb[31:0]}, 64'h0);
    check("oeb_hi", {58'h0, gpio_oeb[37:32]}, 64'h3F);
    wb_write(B + 32'h08, 4'b0011, 32'hA5A5_A5A5);
    check("gpio_o_lo", {32'h0, gpio_out[31:0]}, 64'h0000_A5A5);
    wb_read(B + 32'h08, 32'h0000_A5A5);

    // Set / clear.
    wb_write(B + 32'h08, 4'hF, 32'h0);
    wb_write(B + 32'h30, 4'hF, 32'h0000_0003);
    wb_write(B + 32'h38, 4'hF, 32'h0000_0001);
    wb_read(B + 32'h08, 32'h0000_0002);
    wb_read(B + 32'h30, 32'h0);
    wb_read(B + 32'h38, 32'h0);
    wb_write(B + 32'h30, 4'b0001, 32'hFFFF_FF00);
    check("set_sel_gpio", {32'h0, gpio_out[31:0]}, 64'h2);

    // Rising edge on pin 5: status after edge 2, irq after edge 3.
    wb_write(B + 32'h18, 4'hF, 32'h0000_0020);
    gpio_in[5] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("irq_timing", {63'h0, irq}, {63'h0, k == 3});
    end
    wb_read(B + 32'h28, 32'h0000_0020);
    wb_write(B + 32'h28, 4'hF, 32'h0000_0020);
    check("irq_hold_at_ack", {63'h0, irq}, 64'h1);
    idle(1);
    check("irq_drop", {63'h0, irq}, 64'h0);
    wb_read(B + 32'h28, 32'h0);

    // Rise lands on the same edge as the W1C write: the set wins.
    gpio_in[5] = 1'b0;
    idle(4);
    gpio_in[5] = 1'b1;
    idle(2);
    wb_write(B + 32'h28, 4'hF, 32'h0000_0020);
    wb_read(B + 32'h28, 32'h0000_0020);
    wb_write(B + 32'h28, 4'hF, 32'h0000_0020);
    wb_read(B + 32'h28, 32'h0);

    // Falling edge, then disabling the enable leaves status set.
    wb_write(B + 32'h20, 4'hF, 32'h0000_0020);
    gpio_in[5] = 1'b0;
    idle(4);
    wb_read(B + 32'h28, 32'h0000_0020);
    wb_write(B + 32'h20, 4'hF, 32'h0);
    wb_read(B + 32'h28, 32'h0000_0020);
    check("irq_fall", {63'h0, irq}, 64'h1);
    wb_write(B + 32'h28, 4'hF, 32'h0000_0020);
    wb_read(B + 32'h28, 32'h0);

    // HI bank, unmapped offsets and out-of-window addresses.
    wb_write(B + 32'h0C, 4'hF, 32'hFFFF_FFFF);
    check("gpio_o_hi", {58'h0, gpio_out[37:32]}, 64'h3F);
    wb_read(B + 32'h0C, 32'h0000_003F);
    wb_write(B + 32'h14, 4'h0, 32'hFFFF_FFFF);
    check("oeb_hi_nosel", {58'h0, gpio_oeb[37:32]}, 64'h3F);
    wb_read(B + 32'h80, 32'h0);
    wb_write(B + 32'h80, 4'hF, 32'hFFFF_FFFF);
    wb_no_ack(1'b0, B + 32'h100, 32'h0);
    wb_no_ack(1'b1, B + 32'h108, 32'hFFFF_FFFF);
    wb_read(B + 32'h08, 32'h0000_0002);

    // Input sampling across both words.
    gpio_in = 38'h2A_1234_5678;
    idle(3);
    wb_read(B + 32'h00, 32'h1234_5678);
    wb_read(B + 32'h04, 32'h0000_002A);

    idle(3);
    check("queue_drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
